itof_pipe: RTL and testbench

ITOF_PIPE -- requirements
Module: itof_pipe

---
 rtl/itof_pipe.sv | 85 ++++++++
 tb/tb_itof_pipe.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/itof_pipe.sv
// Three-stage signed 32-bit integer to IEEE-754 single-precision converter.
// Stage 1 takes the magnitude, stage 2 normalises, stage 3 rounds to nearest-even.
module itof_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        valid_in,
    input  logic [31:0] x,
    output logic [31:0] y,
    output logic        valid_out
);

    logic        s1_sign_reg;
    logic [31:0] s1_mag_reg;
    logic        s1_valid_reg;

    logic [4:0]  s2_pos_reg;
    logic [31:0] s2_norm_reg;
    logic        s2_zero_reg;
    logic        s2_sign_reg;
    logic        s2_valid_reg;

    logic [31:0] mag_next;
    logic [4:0]  pos_next;
    logic [31:0] norm_next;

    logic [23:0] sig;
    logic        guard;
    logic        sticky;
    logic        inc;
    logic [24:0] sum;
    logic [7:0]  exp_next;
    logic [22:0] frac_next;
    logic [31:0] y_next;

    // Two's-complement negate; -2^31 maps naturally to 0x80000000.
    assign mag_next = x[31] ? (~x + 32'd1) : x;

    always_comb begin
        pos_next = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (s1_mag_reg[i]) pos_next = 5'(i);
        end
    end

    assign norm_next = s1_mag_reg << (5'd31 - pos_next);

    assign sig    = s2_norm_reg[31:8];
    assign guard  = s2_norm_reg[7];
    assign sticky = |s2_norm_reg[6:0];
    assign inc    = guard & (sticky | sig[0]);
    assign sum    = {1'b0, sig} + {24'd0, inc};

    // A carry out of the significand leaves 1.000..., so only the exponent moves.
    assign exp_next  = 8'd127 + {3'd0, s2_pos_reg} + {7'd0, sum[24]};
    assign frac_next = sum[24] ? 23'd0 : sum[22:0];
    assign y_next    = s2_zero_reg ? 32'd0 : {s2_sign_reg, exp_next, frac_next};

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_sign_reg  <= 1'b0;
            s1_mag_reg   <= 32'd0;
            s1_valid_reg <= 1'b0;
            s2_pos_reg   <= 5'd0;
            s2_norm_reg  <= 32'd0;
            s2_zero_reg  <= 1'b1;
            s2_sign_reg  <= 1'b0;
            s2_valid_reg <= 1'b0;
            y            <= 32'd0;
            valid_out    <= 1'b0;
        end else if (!stall) begin
            s1_sign_reg  <= x[31];
            s1_mag_reg   <= mag_next;
            s1_valid_reg <= valid_in;
            s2_pos_reg   <= pos_next;
            s2_norm_reg  <= norm_next;
            s2_zero_reg  <= (s1_mag_reg == 32'd0);
            s2_sign_reg  <= s1_sign_reg;
            s2_valid_reg <= s1_valid_reg;
            y            <= y_next;
            valid_out    <= s2_valid_reg;
        end
    end

endmodule

// File: tb/tb_itof_pipe.sv
// Directed and randomised bench for itof_pipe; a cycle monitor tracks the
// expected output stream through stalls and resets.
module tb_itof_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        valid_in = 1'b0;
    logic [31:0] x = 32'd0;
    logic [31:0] y;
    logic        valid_out;
    logic [31:0] in_exp = 32'd0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] y;
        int          age;
    } entry_t;
    entry_t exp_q[$];

    logic        model_v = 1'b0;
    logic [31:0] model_y = 32'd0;
    logic        s_rst, s_stall, s_v;
    logic [31:0] s_exp;

    itof_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .valid_in  (valid_in),
        .x         (x),
        .y         (y),
        .valid_out (valid_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, want);
        end
    endtask

    // Reference conversion by integer division-style rounding on the magnitude.
    function automatic logic [31:0] ref_itof(input logic [31:0] v);
        logic        s;
        logic [63:0] mag, q, r, half;
        int          p, sh;
        logic [7:0]  e;
        s   = v[31];
        mag = s ? 64'(-$signed({32'hFFFFFFFF, v})) : {32'd0, v};
        if (mag == 0) return 32'd0;
        p = 0;
        while ((mag >> (p + 1)) != 0) p++;
        e = 8'(127 + p);
        if (p <= 23) begin
            q = mag << (23 - p);
        end else begin
            sh   = p - 23;
            q    = mag >> sh;
            r    = mag & ((64'd1 << sh) - 1);
            half = 64'd1 << (sh - 1);
            if (r > half || (r == half && q[0])) q = q + 1;
            if (q == (64'd1 << 24)) begin
                q = 64'd1 << 23;
                e = e + 8'd1;
            end
        end
        return {s, e, q[22:0]};
    endfunction

    // Monitor: sample inputs at the edge, check outputs 1 ns later.
    always @(posedge clk) begin
        s_rst   = rst;
        s_stall = stall;
        s_v     = valid_in;
        s_exp   = in_exp;
        #1;
        if (s_rst) begin
            exp_q.delete();
            model_v = 1'b0;
            model_y = 32'd0;
            check("reset_valid_out", {31'd0, valid_out}, 32'd0);
            check("reset_y", y, 32'd0);
        end else if (s_stall) begin
            check("stall_valid_out", {31'd0, valid_out}, {31'd0, model_v});
            if (model_v) check("stall_y", y, model_y);
        end else begin
            foreach (exp_q[i]) exp_q[i].age++;
            if (s_v) exp_q.push_back('{y: s_exp, age: 0});
            if (exp_q.size() > 0 && exp_q[0].age == 2) begin
                model_v = 1'b1;
                model_y = exp_q[0].y;
                void'(exp_q.pop_front());
            end else begin
                model_v = 1'b0;
            end
            check("valid_out", {31'd0, valid_out}, {31'd0, model_v});
            if (model_v) check("y", y, model_y);
        end
    end

    task automatic drive(input logic r, input logic s, input logic v,
                         input logic [31:0] xv, input logic [31:0] ev);
        @(negedge clk);
        rst      = r;
        stall    = s;
        valid_in = v;
        x        = xv;
        in_exp   = ev;
    endtask

    task automatic op(input logic [31:0] xv, input logic [31:0] ev);
        drive(1'b0, 1'b0, 1'b1, xv, ev);
        $display("issue x=%08h expect y=%08h", xv, ev);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    logic [31:0] dir_x [13] = '{32'h00000001, 32'hFFFFFFFF, 32'h00000000,
                                32'h01000001, 32'h01000003, 32'h01000005,
                                32'h01000007, 32'h7FFFFFFF, 32'h80000000,
                                32'h00FFFFFF, 32'hFFFFFFFE, 32'h00000003,
                                32'hFEFFFFFF};
    logic [31:0] dir_y [13] = '{32'h3F800000, 32'hBF800000, 32'h00000000,
                                32'h4B800000, 32'h4B800002, 32'h4B800002,
                                32'h4B800004, 32'h4F000000, 32'hCF000000,
                                32'h4B7FFFFF, 32'hC0000000, 32'h40400000,
                                32'hCB800000};

    initial begin
        logic [31:0] rx;
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);

        // Basic, rounding and extreme vectors, back to back.
        for (int i = 0; i < 13; i++) op(dir_x[i], dir_y[i]);
        idle(4);

        // Stall for five cycles in the middle of four operands.
        op(32'd10, 32'h41200000);
        op(32'd100, 32'h42C80000);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b1, 32'h12345678, 32'hDEADBEEF);
        op(32'hFFFFFF9C, 32'hC2C80000);
        op(32'd1000, 32'h447A0000);
        idle(5);

        // Reset with stall while three operands are in flight.
        op(32'd5, 32'h40A00000);
        op(32'd6, 32'h40C00000);
        op(32'd7, 32'h40E00000);
        drive(1'b1, 1'b1, 1'b1, 32'd8, 32'h41000000);
        idle(6);

        // Randomised traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            rx = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) rx = -rx;
            if ($urandom_range(0, 15) == 0) rx = 32'h80000000;
            drive(1'b0, ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) < 7), rx, ref_itof(rx));
        end
        idle(5);

        check("drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
